// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Hunts the incoming serial stream for SYNC_WORD, then deserializes the
//   next DATA_W bits (MSB first) into a word offered on a valid/ready
//   handshake. A completed word that finds the holding register full is
//   dropped and reported on overrun.
//   Optional feature macro: SFR_PARITY_EN adds one even-parity bit after
//   the payload; a bad frame pulses perr and is discarded.
module serial_frame_receiver #(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sIn,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              busy,
    output logic              overrun,
    output logic              perr
);

    localparam int FW = $clog2(SYNC_W + 1);
    localparam int BW = $clog2(DATA_W);
    localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_W);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

`ifdef SFR_PARITY_EN
    typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_DATA = 2'd1, ST_PARITY = 2'd2} state_t;

    // Even parity holds when payload and parity bit XOR to zero.
    function automatic logic parity_ok(input logic [DATA_W-1:0] word, input logic pbit);
        return ~((^word) ^ pbit);
    endfunction
`else
    typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_DATA = 1'b1} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic [SYNC_W-1:0] r_win, w_win_nxt;
    logic [FW-1:0]     r_fill, w_fill_nxt;
    logic [BW-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [DATA_W-1:0] r_dout, w_dout_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              r_perr, w_perr_nxt;
    logic              w_commit;
    logic [DATA_W-1:0] w_word;

    // Next-state, datapath and output decode; all defaults hold current values.
    always_comb begin
        w_state_nxt   = r_state;
        w_win_nxt     = r_win;
        w_fill_nxt    = r_fill;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_commit      = 1'b0;
        w_word        = r_shift;
        w_perr_nxt    = 1'b0;
        w_overrun_nxt = 1'b0;
        w_dout_nxt    = r_dout;
        // A consumed word leaves unless a commit below refills it.
        w_valid_nxt   = r_valid & ~ready;

        case (r_state)
            ST_HUNT: begin
                w_win_nxt = {r_win[SYNC_W-2:0], sIn};
                if (r_fill == FILL_FULL) begin
                    w_fill_nxt = r_fill;
                end else begin
                    w_fill_nxt = r_fill + FILL_ONE;
                end
                // Only a window made entirely of fresh bits may match.
                if ((w_win_nxt == SYNC_WORD) && (w_fill_nxt == FILL_FULL)) begin
                    w_state_nxt  = ST_DATA;
                    w_bitcnt_nxt = {BW{1'b0}};
                end else begin
                    w_state_nxt  = ST_HUNT;
                end
            end
            ST_DATA: begin
                w_shift_nxt = {r_shift[DATA_W-2:0], sIn};
                if (r_bitcnt == BIT_LAST) begin
                    w_bitcnt_nxt = {BW{1'b0}};
`ifdef SFR_PARITY_EN
                    w_state_nxt  = ST_PARITY;
`else
                    w_commit     = 1'b1;
                    w_word       = w_shift_nxt;
                    w_state_nxt  = ST_HUNT;
                    w_win_nxt    = {SYNC_W{1'b0}};
                    w_fill_nxt   = {FW{1'b0}};
`endif
                end else begin
                    w_bitcnt_nxt = r_bitcnt + BIT_ONE;
                end
            end
`ifdef SFR_PARITY_EN
            ST_PARITY: begin
                if (parity_ok(r_shift, sIn)) begin
                    w_commit   = 1'b1;
                    w_word     = r_shift;
                end else begin
                    w_perr_nxt = 1'b1;
                end
                w_state_nxt = ST_HUNT;
                w_win_nxt   = {SYNC_W{1'b0}};
                w_fill_nxt  = {FW{1'b0}};
            end
`endif
            default: begin
                w_state_nxt = ST_HUNT;
                w_win_nxt   = {SYNC_W{1'b0}};
                w_fill_nxt  = {FW{1'b0}};
            end
        endcase

        // Load the holding register if it is empty or being drained now.
        if (w_commit) begin
            if (!r_valid || ready) begin
                w_dout_nxt  = w_word;
                w_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end else begin
            w_overrun_nxt = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != ST_HUNT);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win     <= {SYNC_W{1'b0}};
            r_fill    <= {FW{1'b0}};
            r_bitcnt  <= {BW{1'b0}};
            r_shift   <= {DATA_W{1'b0}};
            r_dout    <= {DATA_W{1'b0}};
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_win     <= w_win_nxt;
            r_fill    <= w_fill_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_dout    <= w_dout_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
            r_perr    <= w_perr_nxt;
        end
    end

    assign dout    = r_dout;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;
`ifdef SFR_PARITY_EN
    assign perr    = r_perr;
`else
    assign perr    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed testbench for serial_frame_receiver (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_serial_frame_receiver;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       sIn   = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic       overrun;
    logic       perr;

    int n_total = 0;
    int n_pass  = 0;

    serial_frame_receiver #(
        .DATA_W   (8),
        .SYNC_W   (4),
        .SYNC_WORD(4'b1101)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sIn    (sIn),
        .ready  (ready),
        .dout   (dout),
        .valid  (valid),
        .busy   (busy),
        .overrun(overrun),
        .perr   (perr)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one serial bit across one rising edge.
    task automatic tick(input logic b);
        sIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync();
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
    endtask

    // Full frame; ready is raised only across the commit edge when rdy=1.
    task automatic send_frame(input logic [7:0] w, input logic pbit, input logic rdy);
        send_sync();
        for (int i = 7; i >= 0; i--) begin
`ifndef SFR_PARITY_EN
            if (i == 0) ready = rdy;
`endif
            tick(w[i]);
        end
`ifdef SFR_PARITY_EN
        ready = rdy;
        tick(pbit);
`endif
        ready = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        tick(1'b0);
        ready = 1'b0;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [17:0] stream;
        logic prev_v;
        int rises;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_dout",    32'(dout),    32'h0);
        check("rst_valid",   32'(valid),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_perr",    32'(perr),    32'h0);
        rst = 1'b0;

        // Frame A5, ready low: busy only after the 4th sync bit
        tick(1'b1); check("busy_e1", 32'(busy), 32'h0);
        tick(1'b1); check("busy_e2", 32'(busy), 32'h0);
        tick(1'b0); check("busy_e3", 32'(busy), 32'h0);
        tick(1'b1);
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            check("busy_data", 32'(busy), 32'h1);
            check("valid_early", 32'(valid), 32'h0);
            tick(w[i]);
        end
`ifdef SFR_PARITY_EN
        check("busy_par", 32'(busy), 32'h1);
        tick(1'b0);
`endif
        check("f1_dout",  32'(dout),  32'hA5);
        check("f1_valid", 32'(valid), 32'h1);
        check("f1_busy",  32'(busy),  32'h0);

        // Second frame while full: overrun pulse, dout held
        send_frame(8'h3C, ^(8'h3C), 1'b0);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_perr",  32'(perr),    32'h0);
        check("ovr_dout",  32'(dout),    32'hA5);
        check("ovr_valid", 32'(valid),   32'h1);
        tick(1'b0);
        check("ovr_end",   32'(overrun), 32'h0);
        consume();
        check("drain_valid", 32'(valid), 32'h0);

        // Back-to-back frames, ready on the second commit edge
        send_frame(8'hA5, ^(8'hA5), 1'b0);
        check("b2b_first", 32'(dout), 32'hA5);
        send_frame(8'h3C, ^(8'h3C), 1'b1);
        check("b2b_dout",  32'(dout),    32'h3C);
        check("b2b_valid", 32'(valid),   32'h1);
        check("b2b_novr",  32'(overrun), 32'h0);
        consume();
        check("b2b_drain", 32'(valid), 32'h0);

`ifndef SFR_PARITY_EN
        // Noise 0110110 already holds 1101 at its bits 2..5, so that is the
        // first match; the payload is the next 8 bits 1011_0111 = B7. The
        // trailing 1s never refill a matching window.
        stream = {7'b0110110, 4'b1101, 7'b1111111};
        rises  = 0;
        for (int i = 17; i >= 0; i--) begin
            prev_v = valid;
            tick(stream[i]);
            if (valid && !prev_v) rises++;
        end
        for (int i = 0; i < 4; i++) begin
            prev_v = valid;
            tick(1'b1);
            if (valid && !prev_v) rises++;
        end
        check("noise_dout",  32'(dout),  32'hB7);
        check("noise_rises", 32'(rises), 32'h1);
        consume();
        tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b0);
`endif

        // Reset mid-frame after the 5th data bit
        send_sync();
        tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b0);
        rst = 1'b1;
        #1;
        check("mrst_dout",    32'(dout),    32'h0);
        check("mrst_valid",   32'(valid),   32'h0);
        check("mrst_busy",    32'(busy),    32'h0);
        check("mrst_overrun", 32'(overrun), 32'h0);
        check("mrst_perr",    32'(perr),    32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(8'h81, ^(8'h81), 1'b0);
        check("post_rst_dout",  32'(dout),  32'h81);
        check("post_rst_valid", 32'(valid), 32'h1);

`ifdef SFR_PARITY_EN
        consume();
        send_frame(8'hA5, 1'b0, 1'b0);
        check("par_ok_dout",  32'(dout),  32'hA5);
        check("par_ok_valid", 32'(valid), 32'h1);
        check("par_ok_perr",  32'(perr),  32'h0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("par_bad_perr",  32'(perr),    32'h1);
        check("par_bad_ovr",   32'(overrun), 32'h0);
        check("par_bad_dout",  32'(dout),    32'hA5);
        check("par_bad_valid", 32'(valid),   32'h1);
        tick(1'b0);
        check("par_perr_end",  32'(perr),    32'h0);
`else
        check("perr_tied", 32'(perr), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
